mc_main_controller_hs: RTL and testbench
========================================

// Module: mc_main_controller_hs
// PURPOSE
//  Next-generation Moore FSM for the multi-cycle RISC-V core.
//  Drives the shared datapath: PC, IR, ALU muxes, register file and unified memory.
//  Extends the base controller in three ways:
//    - memory request/ready handshake with bounded wait states;
//    - optional multi-cycle M-extension (mul/div) issue/wait path;
//    - illegal-instruction and memory-timeout trap state instead of silent return to IF.
// PARAMETERS
//  WAIT_W     4  width of memory wait-state counter; timeout after 2**WAIT_W-1 cycles
//  MULDIV_EN  1  1: R-type with funct7[0]=1 goes to EX_MD; 0: treated as plain R-type
//  TRAP_EN    1  1: illegal op / timeout enter TRAP; 0: illegal op returns to IF, no timeout
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  op         in   7  instr[6:0]
//  funct7_0   in   1  instr[25]; M-extension select
//  zero,neg   in   1  ALU flags; passed through unused, kept for branch unit
//  mem_ready  in   1  memory completed the current access this cycle
//  md_done    in   1  mul/div unit result valid (1-cycle pulse)
//  PCUpdate,adrSrc,memWrite,branch,IRWrite,regWrite  out 1  datapath enables/selects
//  resultSrc,ALUSrcA,ALUSrcB,ALUOp  out 2  datapath mux selects / ALU op class
//  immSrc     out  3  immediate format (0 I, 1 S, 2 B, 3 J, 4 U)
//  mem_req    out  1  memory access request, held until mem_ready
//  md_start   out  1  one-cycle pulse launching mul/div
//  trap       out  1  one-cycle pulse on trap entry
//  trap_cause out  2  0 none, 1 illegal op, 2 memory timeout; held until next trap
//  state_o    out  5  current state (debug)
// BEHAVIOUR
//  Reset / IDLE
//   - rst -> state IDLE, wait counter 0, trap_cause 0.
//   - IDLE drives every output 0; IDLE -> IF unconditionally next cycle.
//  Outputs
//   - Moore decode of the registered state.
//   - Exception: IRWrite/PCUpdate in IF and regWrite in WB_LW are gated by mem_ready.
//   - Unlisted outputs are 0 in every state.
//  Memory states IF, MEM_LW, MEM_S
//   - mem_req=1 and the state is held while mem_ready=0; exit on the mem_ready=1 cycle.
//   - IF decode: adrSrc=0, ALUSrcA=0, ALUSrcB=2, resultSrc=2, IRWrite=PCUpdate=mem_ready.
//   - MEM_S: memWrite=1 every held cycle.
//   - MEM_LW: adrSrc=1; exits to WB_LW, which writes back with resultSrc=1.
//  Wait counter
//   - Clears on entry to any memory state; increments each held cycle; saturates.
//   - Reaching 2**WAIT_W-1 with mem_ready still 0 and TRAP_EN=1: TRAP, cause 2.
//   - mem_ready=1 on the timeout cycle wins: normal exit, no trap.
//  ID decode path: ALUSrcA=1, ALUSrcB=1, immSrc=2. Successors by op:
//   - I -> EX_I -> MEM_I -> IF
//   - R -> EX_R -> MEM_R -> IF
//   - B -> EX_B -> IF
//   - J -> EX_J -> MEM_J -> WB_J -> IF
//   - JALR -> EX_JALR -> MEM_JALR -> MEM_I
//   - LW -> EX_LW -> MEM_LW -> WB_LW -> IF
//   - S -> EX_S -> MEM_S -> IF
//   - U -> EX_U -> IF
//   - Other op: TRAP (cause 1) if TRAP_EN, else IF.
//  Mul/div path (MULDIV_EN=1, op=R, funct7_0=1)
//   - ID -> EX_MD: md_start=1 in the first cycle only.
//   - Hold in EX_MD with ALUSrcA=2, ALUSrcB=0 until md_done -> MEM_R. No timeout.
//  TRAP
//   - Single cycle: trap=1, PCUpdate=1, resultSrc=3 (trap vector), then IF.
//   - trap_cause is updated on TRAP entry.
//  Other rules
//   - rst mid-access drops mem_req asynchronously; no memWrite/regWrite after rst rises.
//   - Encodings are fixed 5-bit; unused codes -> IDLE.
// TESTING
//  T1 reset, mem_ready tied 1
//     -> IDLE 1 cycle, then IF with IRWrite=PCUpdate=1
//     -> add sequence: IF,ID,EX_R,MEM_R; regWrite=1 only in MEM_R.
//  T2 lw, mem_ready low 3 cycles in MEM_LW
//     -> MEM_LW held 4 cycles, mem_req=1 throughout; regWrite=1 once in WB_LW.
//  T3 sw, WAIT_W=2, mem_ready never rises
//     -> 3 cycles of MEM_S, then TRAP: trap pulse, trap_cause=2; then IF.
//  T4 op=7'b1111111 -> TRAP, trap_cause=1 (TRAP_EN=1); TRAP_EN=0 -> IF, trap stays 0.
//  T5 mul (funct7_0=1), md_done after 5 cycles
//     -> md_start pulses once; EX_MD held 5 cycles; then MEM_R, regWrite=1.
//  T6 rst asserted in MEM_S with memWrite=1
//     -> memWrite and mem_req drop same cycle; state IDLE.

Source files
------------

// File: rtl/mc_main_controller_hs.sv
`timescale 1ns/1ps
// Main control FSM for the multi-cycle RISC-V core. Outputs are a Moore decode of the registered state.
// Memory states hold with mem_req until mem_ready. Bounded waits and illegal ops divert to a one-cycle TRAP.
module mc_main_controller_hs #(
   parameter int WAIT_W    = 4,
   parameter bit MULDIV_EN = 1'b1,
   parameter bit TRAP_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       funct7_0,
   input  logic       zero,
   input  logic       neg,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic       PCUpdate,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       branch,
   output logic       IRWrite,
   output logic       regWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] immSrc,
   output logic       mem_req,
   output logic       md_start,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [4:0] state_o
);

   typedef enum logic [4:0] {
      S_IDLE = 5'd0, S_IF, S_ID, S_EX_I, S_MEM_I, S_EX_R, S_MEM_R, S_EX_B,
      S_EX_J, S_MEM_J, S_WB_J, S_EX_JALR, S_MEM_JALR, S_EX_LW, S_MEM_LW,
      S_WB_LW, S_EX_S, S_MEM_S, S_EX_U, S_EX_MD, S_TRAP
   } state_t;

   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_J     = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [WAIT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [1:0]        cause_q, cause_d;
   logic              md_first_q, md_first_d;
   logic              held, timeout;
   logic              unused_flags;

   assign unused_flags = zero ^ neg;

   // The timeout cycle is the last held cycle; mem_ready on that same cycle still exits normally.
   assign held    = (state_q == S_IF || state_q == S_MEM_LW || state_q == S_MEM_S) && !mem_ready;
   assign timeout = held && TRAP_EN && (cnt_q == CNT_MAX - 1'b1);

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE:     state_d = S_IF;
         S_IF:       if (mem_ready) state_d = S_ID; else if (timeout) state_d = S_TRAP;
         S_ID: begin
            case (op)
               OP_I:             state_d = S_EX_I;
               OP_R:             state_d = (MULDIV_EN && funct7_0) ? S_EX_MD : S_EX_R;
               OP_B:             state_d = S_EX_B;
               OP_J:             state_d = S_EX_J;
               OP_JALR:          state_d = S_EX_JALR;
               OP_LW:            state_d = S_EX_LW;
               OP_S:             state_d = S_EX_S;
               OP_LUI, OP_AUIPC: state_d = S_EX_U;
               default:          state_d = TRAP_EN ? S_TRAP : S_IF;
            endcase
         end
         S_EX_I:     state_d = S_MEM_I;
         S_MEM_I:    state_d = S_IF;
         S_EX_R:     state_d = S_MEM_R;
         S_MEM_R:    state_d = S_IF;
         S_EX_B:     state_d = S_IF;
         S_EX_J:     state_d = S_MEM_J;
         S_MEM_J:    state_d = S_WB_J;
         S_WB_J:     state_d = S_IF;
         S_EX_JALR:  state_d = S_MEM_JALR;
         S_MEM_JALR: state_d = S_MEM_I;
         S_EX_LW:    state_d = S_MEM_LW;
         S_MEM_LW:   if (mem_ready) state_d = S_WB_LW; else if (timeout) state_d = S_TRAP;
         S_WB_LW:    state_d = S_IF;
         S_EX_S:     state_d = S_MEM_S;
         S_MEM_S:    if (mem_ready) state_d = S_IF; else if (timeout) state_d = S_TRAP;
         S_EX_U:     state_d = S_IF;
         S_EX_MD:    if (md_done) state_d = S_MEM_R;
         S_TRAP:     state_d = S_IF;
         default:    state_d = S_IDLE;
      endcase
      if (state_d == S_TRAP && state_q != S_TRAP)
         cause_d = (state_q == S_ID) ? 2'd1 : 2'd2;
   end

   always_comb begin
      cnt_d = '0;
      if (held && !timeout)
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      md_first_d = (state_d == S_EX_MD) && (state_q != S_EX_MD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cause_q    <= 2'd0;
         md_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cause_q    <= cause_d;
         md_first_q <= md_first_d;
      end
   end

   always_comb begin
      PCUpdate = 1'b0; adrSrc = 1'b0; memWrite = 1'b0; branch = 1'b0;
      IRWrite = 1'b0; regWrite = 1'b0; resultSrc = 2'd0; ALUSrcA = 2'd0;
      ALUSrcB = 2'd0; ALUOp = 2'd0; immSrc = 3'd0; mem_req = 1'b0;
      md_start = 1'b0; trap = 1'b0;
      case (state_q)
         S_IF:       begin mem_req = 1'b1; ALUSrcB = 2'd2; resultSrc = 2'd2; IRWrite = mem_ready; PCUpdate = mem_ready; end
         S_ID:       begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; immSrc = 3'd2; end
         S_EX_I:     begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUOp = 2'd2; end
         S_MEM_I, S_MEM_R, S_MEM_J: regWrite = 1'b1;
         S_EX_R:     begin ALUSrcA = 2'd2; ALUOp = 2'd2; end
         S_EX_B:     begin ALUSrcA = 2'd2; ALUOp = 2'd1; branch = 1'b1; immSrc = 3'd2; end
         S_EX_J, S_EX_JALR: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; end
         S_WB_J:     begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; immSrc = 3'd3; resultSrc = 2'd2; PCUpdate = 1'b1; end
         S_MEM_JALR: begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; resultSrc = 2'd2; PCUpdate = 1'b1; end
         S_EX_LW:    begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; end
         S_MEM_LW:   begin adrSrc = 1'b1; mem_req = 1'b1; end
         S_WB_LW:    begin resultSrc = 2'd1; regWrite = mem_ready; end
         S_EX_S:     begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; immSrc = 3'd1; end
         S_MEM_S:    begin adrSrc = 1'b1; memWrite = 1'b1; mem_req = 1'b1; end
         S_EX_U:     begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; immSrc = 3'd4; resultSrc = 2'd2; regWrite = 1'b1; end
         S_EX_MD:    begin ALUSrcA = 2'd2; ALUOp = 2'd2; md_start = md_first_q; end
         S_TRAP:     begin trap = 1'b1; PCUpdate = 1'b1; resultSrc = 2'd3; end
         default:    ;
      endcase
   end

   assign trap_cause = cause_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_mc_main_controller_hs.sv
`timescale 1ns/1ps
// Bench for mc_main_controller_hs: three parameter sets driven with the same stimulus and
// compared every cycle against an instruction-path model, plus directed literal checks.
module tb_mc_main_controller_hs;
   localparam int NI = 3;
   localparam int WW  [NI] = '{4, 2, 2};
   localparam int MDE [NI] = '{1, 1, 0};
   localparam int TEN [NI] = '{1, 1, 0};

   localparam int ST_IDLE = 0, ST_IF = 1, ST_ID = 2, ST_EX_I = 3, ST_MEM_I = 4, ST_EX_R = 5,
                  ST_MEM_R = 6, ST_EX_B = 7, ST_EX_J = 8, ST_MEM_J = 9, ST_WB_J = 10,
                  ST_EX_JALR = 11, ST_MEM_JALR = 12, ST_EX_LW = 13, ST_MEM_LW = 14,
                  ST_WB_LW = 15, ST_EX_S = 16, ST_MEM_S = 17, ST_EX_U = 18, ST_EX_MD = 19,
                  ST_TRAP = 20;

   localparam logic [6:0] OP_I = 7'b0010011, OP_R = 7'b0110011, OP_B = 7'b1100011,
                          OP_J = 7'b1101111, OP_JALR = 7'b1100111, OP_LW = 7'b0000011,
                          OP_S = 7'b0100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                          OP_BAD = 7'b1111111;

   typedef struct packed {
      logic pcu, adr, mw, br, irw, rw;
      logic [1:0] rs, asa, asb, aop;
      logic [2:0] imm;
      logic mreq, mds, trp;
      logic [1:0] cause;
      logic [4:0] st;
   } out_t;

   logic clk, rst, funct7_0, zero, neg, mem_ready, md_done;
   logic [6:0] op;
   out_t dut_o [NI];
   out_t obs [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic pcu, adr, mw, br, irw, rw, mreq, mds, trp;
      logic [1:0] rs, asa, asb, aop, cause;
      logic [2:0] imm;
      logic [4:0] st;
      mc_main_controller_hs #(.WAIT_W(WW[g]), .MULDIV_EN(MDE[g] != 0), .TRAP_EN(TEN[g] != 0)) u_dut (
         .clk(clk), .rst(rst), .op(op), .funct7_0(funct7_0), .zero(zero), .neg(neg),
         .mem_ready(mem_ready), .md_done(md_done),
         .PCUpdate(pcu), .adrSrc(adr), .memWrite(mw), .branch(br), .IRWrite(irw), .regWrite(rw),
         .resultSrc(rs), .ALUSrcA(asa), .ALUSrcB(asb), .ALUOp(aop), .immSrc(imm),
         .mem_req(mreq), .md_start(mds), .trap(trp), .trap_cause(cause), .state_o(st));
      assign dut_o[g] = {pcu, adr, mw, br, irw, rw, rs, asa, asb, aop, imm, mreq, mds, trp, cause, st};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Model: current state, cycles spent in it, remaining planned path after ID, trap cause.
   int m_st [NI];
   int m_age [NI];
   int m_cause [NI];
   int m_path [NI][4];
   int m_plen [NI];
   int m_pidx [NI];

   function automatic void reset_model(int k);
      m_st[k] = ST_IDLE; m_age[k] = 0; m_cause[k] = 0; m_plen[k] = 0; m_pidx[k] = 0;
   endfunction

   function automatic void add(int k, int s);
      m_path[k][m_plen[k]] = s;
      m_plen[k]++;
   endfunction

   function automatic int pop(int k);
      int s;
      s = ST_IF;
      if (m_pidx[k] < m_plen[k]) begin
         s = m_path[k][m_pidx[k]];
         m_pidx[k]++;
      end
      return s;
   endfunction

   function automatic void plan(int k, logic [6:0] o, logic f);
      m_plen[k] = 0; m_pidx[k] = 0;
      case (o)
         OP_I:    begin add(k, ST_EX_I); add(k, ST_MEM_I); end
         OP_R:    begin add(k, (MDE[k] != 0 && f) ? ST_EX_MD : ST_EX_R); add(k, ST_MEM_R); end
         OP_B:    add(k, ST_EX_B);
         OP_J:    begin add(k, ST_EX_J); add(k, ST_MEM_J); add(k, ST_WB_J); end
         OP_JALR: begin add(k, ST_EX_JALR); add(k, ST_MEM_JALR); add(k, ST_MEM_I); end
         OP_LW:   begin add(k, ST_EX_LW); add(k, ST_MEM_LW); add(k, ST_WB_LW); end
         OP_S:    begin add(k, ST_EX_S); add(k, ST_MEM_S); end
         OP_LUI, OP_AUIPC: add(k, ST_EX_U);
         default: if (TEN[k] != 0) add(k, ST_TRAP);
      endcase
   endfunction

   function automatic void advance(int k, logic [6:0] o, logic f, logic mr, logic mdd);
      int nxt;
      bit held;
      held = 1'b0;
      nxt = ST_IF;
      case (m_st[k])
         ST_IDLE, ST_TRAP: nxt = ST_IF;
         ST_IF, ST_MEM_LW, ST_MEM_S: begin
            if (mr) nxt = (m_st[k] == ST_IF) ? ST_ID : pop(k);
            else if (TEN[k] != 0 && m_age[k] == (1 << WW[k]) - 2) begin
               nxt = ST_TRAP; m_cause[k] = 2;
            end else held = 1'b1;
         end
         ST_ID: begin
            plan(k, o, f);
            nxt = pop(k);
            if (nxt == ST_TRAP) m_cause[k] = 1;
         end
         ST_EX_MD: if (mdd) nxt = pop(k); else held = 1'b1;
         default:  nxt = pop(k);
      endcase
      if (held) m_age[k]++;
      else begin m_age[k] = 0; m_st[k] = nxt; end
   endfunction

   function automatic out_t expect_out(int k, logic mr);
      out_t e;
      e = '0;
      e.st = 5'(m_st[k]);
      e.cause = 2'(m_cause[k]);
      case (m_st[k])
         ST_IF:       begin e.mreq = 1'b1; e.asb = 2'd2; e.rs = 2'd2; e.irw = mr; e.pcu = mr; end
         ST_ID:       begin e.asa = 2'd1; e.asb = 2'd1; e.imm = 3'd2; end
         ST_EX_I:     begin e.asa = 2'd2; e.asb = 2'd1; e.aop = 2'd2; end
         ST_MEM_I, ST_MEM_R, ST_MEM_J: e.rw = 1'b1;
         ST_EX_R:     begin e.asa = 2'd2; e.aop = 2'd2; end
         ST_EX_B:     begin e.asa = 2'd2; e.aop = 2'd1; e.br = 1'b1; e.imm = 3'd2; end
         ST_EX_J, ST_EX_JALR: begin e.asa = 2'd1; e.asb = 2'd2; end
         ST_WB_J:     begin e.asa = 2'd1; e.asb = 2'd1; e.imm = 3'd3; e.rs = 2'd2; e.pcu = 1'b1; end
         ST_MEM_JALR: begin e.asa = 2'd2; e.asb = 2'd1; e.rs = 2'd2; e.pcu = 1'b1; end
         ST_EX_LW:    begin e.asa = 2'd2; e.asb = 2'd1; end
         ST_MEM_LW:   begin e.adr = 1'b1; e.mreq = 1'b1; end
         ST_WB_LW:    begin e.rs = 2'd1; e.rw = mr; end
         ST_EX_S:     begin e.asa = 2'd2; e.asb = 2'd1; e.imm = 3'd1; end
         ST_MEM_S:    begin e.adr = 1'b1; e.mw = 1'b1; e.mreq = 1'b1; end
         ST_EX_U:     begin e.asa = 2'd1; e.asb = 2'd1; e.imm = 3'd4; e.rs = 2'd2; e.rw = 1'b1; end
         ST_EX_MD:    begin e.asa = 2'd2; e.aop = 2'd2; e.mds = (m_age[k] == 0); end
         ST_TRAP:     begin e.trp = 1'b1; e.pcu = 1'b1; e.rs = 2'd3; end
         default:     ;
      endcase
      return e;
   endfunction

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   function automatic void chk_o(int k, out_t act, out_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL model_inst%0d t=%0t: got %h expected %h (state got %0d expected %0d)",
                  k, $time, act, exp, act.st, exp.st);
      end
   endfunction

   task automatic step(input logic [6:0] o, input logic f, input logic mr, input logic mdd);
      @(negedge clk);
      rst = 1'b0;
      op = o; funct7_0 = f; mem_ready = mr; md_done = mdd;
      zero = 1'($urandom); neg = 1'($urandom);
      #1;
      for (int k = 0; k < NI; k++) begin
         obs[k] = dut_o[k];
         chk_o(k, obs[k], expect_out(k, mr));
      end
      @(posedge clk);
      for (int k = 0; k < NI; k++) advance(k, o, f, mr, mdd);
   endtask

   task automatic assert_rst();
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         reset_model(k);
         obs[k] = dut_o[k];
         chk_o(k, obs[k], expect_out(k, mem_ready));
      end
      @(posedge clk);
   endtask

   function automatic logic [6:0] pick_op();
      case ($urandom_range(0, 11))
         0: return OP_I;   1: return OP_R;    2: return OP_R;  3: return OP_B;
         4: return OP_J;   5: return OP_JALR; 6: return OP_LW; 7: return OP_S;
         8: return OP_LUI; 9: return OP_AUIPC; 10: return OP_BAD;
         default: return 7'($urandom);
      endcase
   endfunction

   initial begin
      int cnt;
      logic mr;
      rst = 1'b1; op = '0; funct7_0 = 1'b0; zero = 1'b0; neg = 1'b0;
      mem_ready = 1'b0; md_done = 1'b0;
      for (int k = 0; k < NI; k++) reset_model(k);
      #2;
      for (int k = 0; k < NI; k++) chk($sformatf("reset_outputs_inst%0d", k), int'(dut_o[k]), 0);

      // add with memory always ready: IDLE, IF, ID, EX_R, MEM_R, IF
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_idle", int'(obs[0]), 0);
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_if_state", int'(obs[0].st), 1);
      chk("t1_if_irwrite", int'(obs[0].irw), 1); chk("t1_if_pcupdate", int'(obs[0].pcu), 1);
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_id_state", int'(obs[0].st), 2); chk("t1_id_rw", int'(obs[0].rw), 0);
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_exr_state", int'(obs[0].st), 5); chk("t1_exr_rw", int'(obs[0].rw), 0);
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_memr_state", int'(obs[0].st), 6); chk("t1_memr_rw", int'(obs[0].rw), 1);
      step(OP_R, 1'b0, 1'b1, 1'b0); chk("t1_back_if", int'(obs[0].st), 1);

      // lw with three not-ready cycles in MEM_LW
      step(OP_LW, 1'b0, 1'b1, 1'b0); chk("t2_id", int'(obs[0].st), 2);
      cnt = 0;
      step(OP_LW, 1'b0, 1'b1, 1'b0); chk("t2_exlw", int'(obs[0].st), 13); cnt += int'(obs[0].rw);
      for (int i = 0; i < 4; i++) begin
         step(OP_LW, 1'b0, (i == 3), 1'b0);
         chk("t2_memlw_state", int'(obs[0].st), 14); chk("t2_memlw_req", int'(obs[0].mreq), 1);
         cnt += int'(obs[0].rw);
      end
      step(OP_LW, 1'b0, 1'b1, 1'b0); chk("t2_wblw", int'(obs[0].st), 15); cnt += int'(obs[0].rw);
      step(OP_LW, 1'b0, 1'b1, 1'b0); chk("t2_if", int'(obs[0].st), 1); cnt += int'(obs[0].rw);
      chk("t2_regwrite_count", cnt, 1);

      // sw on WAIT_W=2 instance, memory never ready: 3 MEM_S cycles then TRAP cause 2
      assert_rst();
      step(OP_S, 1'b0, 1'b1, 1'b0); step(OP_S, 1'b0, 1'b1, 1'b0);
      step(OP_S, 1'b0, 1'b1, 1'b0); step(OP_S, 1'b0, 1'b0, 1'b0);
      chk("t3_exs", int'(obs[1].st), 16);
      for (int i = 0; i < 3; i++) begin
         step(OP_S, 1'b0, 1'b0, 1'b0);
         chk("t3_mems_state", int'(obs[1].st), 17); chk("t3_mems_mw", int'(obs[1].mw), 1);
      end
      step(OP_S, 1'b0, 1'b0, 1'b0);
      chk("t3_trap_state", int'(obs[1].st), 20); chk("t3_trap_pulse", int'(obs[1].trp), 1);
      chk("t3_trap_cause", int'(obs[1].cause), 2);
      step(OP_S, 1'b0, 1'b0, 1'b0);
      chk("t3_after_if", int'(obs[1].st), 1); chk("t3_pulse_gone", int'(obs[1].trp), 0);
      chk("t3_cause_held", int'(obs[1].cause), 2);

      // illegal op: trap cause 1 with TRAP_EN, plain return to IF without
      assert_rst();
      step(OP_BAD, 1'b0, 1'b1, 1'b0); step(OP_BAD, 1'b0, 1'b1, 1'b0); step(OP_BAD, 1'b0, 1'b1, 1'b0);
      step(OP_BAD, 1'b0, 1'b1, 1'b0);
      chk("t4_trap_state", int'(obs[0].st), 20); chk("t4_trap_cause", int'(obs[0].cause), 1);
      chk("t4_noten_state", int'(obs[2].st), 1); chk("t4_noten_trap", int'(obs[2].trp), 0);
      chk("t4_noten_cause", int'(obs[2].cause), 0);

      // mul with md_done on the fifth EX_MD cycle
      assert_rst();
      step(OP_R, 1'b1, 1'b1, 1'b0); step(OP_R, 1'b1, 1'b1, 1'b0); step(OP_R, 1'b1, 1'b1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(OP_R, 1'b1, 1'b1, (i == 4));
         chk("t5_exmd_state", int'(obs[0].st), 19); cnt += int'(obs[0].mds);
         if (i == 0) chk("t5_first_start", int'(obs[0].mds), 1);
      end
      chk("t5_start_count", cnt, 1);
      step(OP_R, 1'b1, 1'b1, 1'b0);
      chk("t5_memr_state", int'(obs[0].st), 6); chk("t5_memr_rw", int'(obs[0].rw), 1);

      // reset while a store is in progress
      assert_rst();
      step(OP_S, 1'b0, 1'b1, 1'b0); step(OP_S, 1'b0, 1'b1, 1'b0); step(OP_S, 1'b0, 1'b1, 1'b0);
      step(OP_S, 1'b0, 1'b0, 1'b0); step(OP_S, 1'b0, 1'b0, 1'b0);
      chk("t6_mems_mw", int'(obs[0].mw), 1);
      assert_rst();
      chk("t6_rst_mw", int'(obs[0].mw), 0); chk("t6_rst_req", int'(obs[0].mreq), 0);
      chk("t6_rst_state", int'(obs[0].st), 0);

      for (int c = 0; c < 3000; c++) begin
         case ((c / 150) % 3)
            0:       mr = ($urandom_range(0, 9) < 8);
            1:       mr = 1'b0;
            default: mr = ($urandom_range(0, 9) < 4);
         endcase
         step(pick_op(), 1'($urandom), mr, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 199) == 0) assert_rst();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
